commit_safety_arbiter: RTL and testbench

//  Parametrised commit-safety gate for NUM_REQ requesters (post office, mailbox, future units).
//  - A requester may perform its irreversible action only while holding the grant.
//  - A grant is given only when the requester's tag equals the control unit's graduation-head tag.
//  - Matching requesters are served in round-robin order; the grant is held until the requester signals done.
//  - A watchdog flags requesters stalled on a mismatched head.

---
 rtl/commit_safety_arbiter.sv | 165 ++++++++++++++++
 tb/tb_commit_safety_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/commit_safety_arbiter.sv
// Commit-safety gate: grants one requester at a time the right to perform an
// irreversible action, only when its tag matches the graduation-head tag.
// Eligible requesters are served round-robin and keep the grant until done,
// withdrawal or flush. A watchdog flags requesters stuck on a mismatched head.
//
// Handshake: a channel requests by holding req_valid_i high; once grant_o for
// that channel is high it may act, and it ends the grant with a one-cycle
// done_i pulse or by dropping req_valid_i. The grant falls on the next edge.
module commit_safety_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int TAG_W       = 8,
    parameter int CHECK_EN    = 1,
    parameter int STALL_LIMIT = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag_i,
    input  logic                     head_valid_i,
    input  logic [TAG_W-1:0]         head_tag_i,
    input  logic [NUM_REQ-1:0]       done_i,
    input  logic                     flush_i,
    output logic [NUM_REQ-1:0]       grant_o,
    output logic                     busy_o,
    output logic                     stall_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STALL_LIMIT);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } state_t;

    state_t             r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [PTR_W-1:0]   r_owner;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic               r_stall;

    state_t             w_state_nxt;
    logic [NUM_REQ-1:0] w_grant_nxt;
    logic [PTR_W-1:0]   w_owner_nxt;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_stall_nxt;

    logic [NUM_REQ-1:0] w_elig;
    logic               w_found_hi;
    logic               w_found_any;
    logic [PTR_W-1:0]   w_win_hi;
    logic [PTR_W-1:0]   w_win_lo;
    logic [PTR_W-1:0]   w_winner;
    logic               w_release;

    // Per-channel eligibility: valid request whose tag matches the head (unless checking is off)
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (CHECK_EN != 0) begin
                w_elig[i] = req_valid_i[i] & head_valid_i &
                            (req_tag_i[i*TAG_W +: TAG_W] == head_tag_i);
            end else begin
                w_elig[i] = req_valid_i[i];
            end
        end
    end

    // Round-robin pick: lowest eligible index at/above rr_ptr, else lowest eligible overall (wrap)
    always_comb begin
        w_found_hi  = 1'b0;
        w_found_any = 1'b0;
        w_win_hi    = '0;
        w_win_lo    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_found_any = 1'b1;
                w_win_lo    = PTR_W'(i);
                if (PTR_W'(i) >= r_rr_ptr) begin
                    w_found_hi = 1'b1;
                    w_win_hi   = PTR_W'(i);
                end
            end
        end
        w_winner = w_found_hi ? w_win_hi : w_win_lo;
    end

    // Grant ends when the owner reports done or withdraws its request
    always_comb begin
        w_release = done_i[r_owner] | ~req_valid_i[r_owner];
    end

    // Next-state logic: flush dominates, IDLE picks a winner, GRANTED waits for release
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_rr_ptr;
        w_cnt_nxt   = r_stall_cnt;
        if (flush_i) begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found_any) begin
                        w_state_nxt = ST_GRANTED;
                        w_grant_nxt = NUM_REQ'(1) << w_winner;
                        w_owner_nxt = w_winner;
                        w_ptr_nxt   = (w_winner == PTR_LAST) ? '0 : w_winner + PTR_W'(1);
                        w_cnt_nxt   = '0;
                    end else if (|req_valid_i) begin
                        // Requests exist but none match the head: count toward the watchdog
                        w_cnt_nxt = (r_stall_cnt == CNT_MAX) ? r_stall_cnt
                                                              : r_stall_cnt + CNT_W'(1);
                    end else begin
                        w_cnt_nxt = '0;
                    end
                end
                ST_GRANTED: begin
                    w_cnt_nxt = '0;
                    if (w_release) begin
                        w_state_nxt = ST_IDLE;
                        w_grant_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
        w_stall_nxt = (STALL_LIMIT != 0) && (w_cnt_nxt == CNT_MAX);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_stall_cnt <= '0;
            r_stall     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_owner     <= w_owner_nxt;
            r_rr_ptr    <= w_ptr_nxt;
            r_stall_cnt <= w_cnt_nxt;
            r_stall     <= w_stall_nxt;
        end
    end

    assign grant_o = r_grant;
    assign busy_o  = (r_state == ST_GRANTED);
    assign stall_o = r_stall;

endmodule

// File: tb/tb_commit_safety_arbiter.sv
// Bench for commit_safety_arbiter: two instances share stimulus, one with tag
// checking and a 4-cycle watchdog, one with checking and watchdog disabled.
module tb_commit_safety_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [15:0] req_tag;
    logic        head_valid;
    logic [7:0]  head_tag;
    logic [1:0]  done;
    logic        flush;

    logic [1:0]  grant_a;
    logic        busy_a;
    logic        stall_a;
    logic [1:0]  grant_b;
    logic        busy_b;
    logic        stall_b;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] exp_q_a[$];
    logic [3:0] exp_q_b[$];

    int m_owner[2];
    int m_ptr[2];
    int m_cnt[2];

    commit_safety_arbiter #(
        .NUM_REQ(2), .TAG_W(8), .CHECK_EN(1), .STALL_LIMIT(4)
    ) dut_a (
        .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_tag_i(req_tag),
        .head_valid_i(head_valid), .head_tag_i(head_tag), .done_i(done),
        .flush_i(flush), .grant_o(grant_a), .busy_o(busy_a), .stall_o(stall_a)
    );

    commit_safety_arbiter #(
        .NUM_REQ(2), .TAG_W(8), .CHECK_EN(0), .STALL_LIMIT(0)
    ) dut_b (
        .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_tag_i(req_tag),
        .head_valid_i(head_valid), .head_tag_i(head_tag), .done_i(done),
        .flush_i(flush), .grant_o(grant_b), .busy_o(busy_b), .stall_o(stall_b)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks which channel owns the grant, the next channel
    // to favour, and how long requests have waited on a mismatched head.
    task automatic model_step(input int id, input bit chk, input int lim);
        bit el[2];
        bit any_valid;
        int w;
        int g;
        any_valid = (req_valid != 2'b00);
        for (int i = 0; i < 2; i++)
            el[i] = req_valid[i] && (!chk || (head_valid && (req_tag[i*8 +: 8] == head_tag)));
        if (rst) begin
            m_owner[id] = -1;
            m_ptr[id]   = 0;
            m_cnt[id]   = 0;
        end else if (flush) begin
            m_owner[id] = -1;
            m_cnt[id]   = 0;
        end else if (m_owner[id] >= 0) begin
            m_cnt[id] = 0;
            if (done[m_owner[id]] || !req_valid[m_owner[id]]) m_owner[id] = -1;
        end else begin
            w = -1;
            for (int k = 0; k < 2; k++) begin
                if (w < 0 && el[(m_ptr[id] + k) % 2]) w = (m_ptr[id] + k) % 2;
            end
            if (w >= 0) begin
                m_owner[id] = w;
                m_ptr[id]   = (w + 1) % 2;
                m_cnt[id]   = 0;
            end else if (any_valid) begin
                m_cnt[id] = (m_cnt[id] < lim) ? m_cnt[id] + 1 : lim;
            end else begin
                m_cnt[id] = 0;
            end
        end
        g = (m_owner[id] >= 0) ? (1 << m_owner[id]) : 0;
        if (id == 0)
            exp_q_a.push_back({g[1:0], m_owner[id] >= 0, lim != 0 && m_cnt[id] == lim});
        else
            exp_q_b.push_back({g[1:0], m_owner[id] >= 0, lim != 0 && m_cnt[id] == lim});
    endtask

    // Model advances on each active edge with the inputs the DUT sees
    always @(posedge clk) begin
        model_step(0, 1'b1, 4);
        model_step(1, 1'b0, 0);
    end

    // Scoreboard: compare both DUTs against the model every cycle
    always @(negedge clk) begin
        logic [3:0] e;
        if (exp_q_a.size() > 0) begin
            e = exp_q_a.pop_front();
            check("model_a", {28'd0, grant_a, busy_a, stall_a}, {28'd0, e});
        end
        if (exp_q_b.size() > 0) begin
            e = exp_q_b.pop_front();
            check("model_b", {28'd0, grant_b, busy_b, stall_b}, {28'd0, e});
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 2'b00; req_tag = 16'h0000; head_valid = 1'b0;
        head_tag = 8'h00; done = 2'b00; flush = 1'b0;
        cyc(2);
        check("reset_grant", {30'd0, grant_a}, 32'd0);
        check("reset_busy", {31'd0, busy_a}, 32'd0);
        check("reset_stall", {31'd0, stall_a}, 32'd0);
        rst = 1'b0;

        // T1: both match, round-robin ch0 then ch1 with one idle cycle between
        head_valid = 1'b1; head_tag = 8'h05; req_tag = 16'h0505; req_valid = 2'b11;
        cyc(1); check("t1_first", {30'd0, grant_a}, 32'h1);
        check("t1_busy", {31'd0, busy_a}, 32'd1);
        done = 2'b01;
        cyc(1); check("t1_done0", {30'd0, grant_a}, 32'h0);
        done = 2'b00;
        cyc(1); check("t1_second", {30'd0, grant_a}, 32'h2);
        done = 2'b10;
        cyc(1); check("t1_done1", {30'd0, grant_a}, 32'h0);
        done = 2'b00; req_valid = 2'b00;
        cyc(1);

        // T2: only ch1 matches; head change and stray done do not revoke
        req_tag = 16'h0507; req_valid = 2'b11;
        cyc(1); check("t2_grant", {30'd0, grant_a}, 32'h2);
        done = 2'b01;
        cyc(1); check("t2_stray_done", {30'd0, grant_a}, 32'h2);
        done = 2'b00; head_tag = 8'h07;
        cyc(1); check("t2_head_change", {30'd0, grant_a}, 32'h2);
        done = 2'b10;
        cyc(1); check("t2_release", {30'd0, grant_a}, 32'h0);
        done = 2'b00; req_valid = 2'b00;
        cyc(1);

        // T3: tag checking disabled grants without a valid head
        head_valid = 1'b0; req_valid = 2'b01;
        cyc(1); check("t3_nocheck", {30'd0, grant_b}, 32'h1);
        check("t3_checked", {30'd0, grant_a}, 32'h0);
        req_valid = 2'b00;
        cyc(1);

        // T4: flush aborts the grant and blocks granting while asserted
        head_valid = 1'b1; head_tag = 8'h05; req_tag = 16'h0005; req_valid = 2'b01;
        cyc(1); check("t4_grant", {30'd0, grant_a}, 32'h1);
        flush = 1'b1;
        cyc(1); check("t4_flush_grant", {30'd0, grant_a}, 32'h0);
        check("t4_flush_busy", {31'd0, busy_a}, 32'd0);
        cyc(1); check("t4_flush_idle", {30'd0, grant_a}, 32'h0);
        flush = 1'b0;
        cyc(1); check("t4_regrant", {30'd0, grant_a}, 32'h1);
        req_valid = 2'b00;
        cyc(1);

        // T5: watchdog on a mismatched head, cleared by a matching head
        head_tag = 8'h02; req_tag = 16'h0001; req_valid = 2'b01;
        cyc(3); check("t5_below", {31'd0, stall_a}, 32'd0);
        cyc(1); check("t5_fire", {31'd0, stall_a}, 32'd1);
        cyc(2); check("t5_sat", {31'd0, stall_a}, 32'd1);
        check("t5_stall_b", {31'd0, stall_b}, 32'd0);
        head_tag = 8'h01;
        cyc(1); check("t5_clear", {31'd0, stall_a}, 32'd0);
        check("t5_grant", {30'd0, grant_a}, 32'h1);
        done = 2'b01;
        cyc(1);
        done = 2'b00; req_valid = 2'b00;
        cyc(1);

        // T6: reset while ch1 holds the grant
        head_tag = 8'h05; req_tag = 16'h0505; req_valid = 2'b10;
        cyc(1); check("t6_grant", {30'd0, grant_a}, 32'h2);
        rst = 1'b1;
        cyc(1); check("t6_rst_grant", {30'd0, grant_a}, 32'h0);
        check("t6_rst_busy", {31'd0, busy_a}, 32'd0);
        check("t6_rst_stall", {31'd0, stall_a}, 32'd0);
        rst = 1'b0; req_valid = 2'b11;
        cyc(1); check("t6_post", {30'd0, grant_a}, 32'h1);
        req_valid = 2'b00;
        cyc(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
